pipe_in_block_fifo: RTL and testbench
=====================================

PIPE_IN_BLOCK_FIFO -- requirements
Module: pipe_in_block_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: FIFO capacity in 16-bit words; power of two, at least 4.
REQ-002 SHALL have parameter BLOCK_WORDS, default 256: host block-transfer length in words; at most DEPTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, which is the host-interface clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pipe_in_write, input, 1 bit: write strobe from the block-throttled pipe-in endpoint.
REQ-006 SHALL have port pipe_in_data, input, 16 bits: write data, valid when pipe_in_write is high.
REQ-007 SHALL have port pipe_in_ready, output, 1 bit: the endpoint's ep_ready, meaning one full block of space is free.
REQ-008 SHALL have port blockstrobe, input, 1 bit: the endpoint's ep_blockstrobe, pulsed one cycle before each block.
REQ-009 SHALL have port dout, output, 16 bits: downstream data.
REQ-010 SHALL have port dout_valid, output, 1 bit: dout holds a valid word.
REQ-011 SHALL have port dout_ready, input, 1 bit: the downstream consumer accepts dout.
REQ-012 SHALL have port level, output, log2(DEPTH)+1 bits: words held, including the output register.
REQ-013 SHALL have port overflow_count, output, 16 bits: count of dropped writes.
REQ-014 SHALL have port block_count, output, 16 bits: count of blockstrobe pulses.

Function
REQ-015 SHALL accept a write when pipe_in_write=1 and level<DEPTH; level is taken as the registered value at the start of the cycle.
REQ-016 SHALL drop a write made while level==DEPTH, even if a read occurs in the same cycle, and SHALL increment overflow_count, saturating at 16'hFFFF.
REQ-017 SHALL complete a transfer on a cycle where dout_valid=1 and dout_ready=1; the next word or dout_valid=0 SHALL appear on the following cycle.
REQ-018 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-019 SHALL be first-word-fall-through: a word written at cycle N into an empty FIFO SHALL show dout_valid=1 at cycle N+2, with dout equal to that word.
REQ-020 SHALL sustain one write and one read per cycle when neither empty nor full, with no bubbles on dout_valid.
REQ-021 SHALL update level each cycle as level + accepted_write - completed_read; a simultaneous write and read SHALL leave level unchanged.
REQ-022 SHALL register pipe_in_ready as (DEPTH - level_next) >= BLOCK_WORDS, so it is valid one cycle after the level change.
REQ-023 SHALL drive pipe_in_ready high when BLOCK_WORDS==DEPTH and level==0.
REQ-024 SHALL increment block_count on each cycle where blockstrobe=1, wrapping at 16'hFFFF to 0.
REQ-025 SHALL preserve word order exactly across pointer wrap-around; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 SHALL use a storage read latency of one cycle, with the output register acting as a prefetch stage.

Reset
REQ-027 SHALL, while reset=1, clear the pointers, set level=0, dout_valid=0, dout=16'h0000, pipe_in_ready=0, overflow_count=0 and block_count=0.
REQ-028 SHALL assert pipe_in_ready on the first cycle after reset deasserts, provided BLOCK_WORDS<=DEPTH.
REQ-029 SHALL, on reset during a transfer, discard all stored data and ignore pipe_in_write and dout_ready in the reset cycle.

Structure
REQ-030 SHALL place default DEPTH, default BLOCK_WORDS and a clog2 helper function in the shared package pipe_fifo_pkg.
REQ-031 SHALL implement storage as the sub-module pipe_fifo_ram: simple dual-port, one write port, one registered read port, inferable as block RAM.
REQ-032 SHALL contain the control logic (pointers, level, prefetch and counters) in pipe_in_block_fifo itself.

Verification
REQ-033 SHALL test reset and ready: release reset -> pipe_in_ready=1 on the next cycle, level=0, dout_valid=0, both counters 0.
REQ-034 SHALL test latency: write 16'hA5A5 at cycle N with dout_ready=0 -> dout_valid=1 and dout=16'hA5A5 at N+2, level=1.
REQ-035 SHALL test block throttling (DEPTH=1024, BLOCK_WORDS=256): write 769 words, no reads -> pipe_in_ready=0 one cycle after word 769; read 1 word -> pipe_in_ready=1.
REQ-036 SHALL test overflow: fill 1024 words, then write 3 more while asserting a read on the first of them -> level stays 1023 then 1024, overflow_count increments per dropped write, no stored data corrupted.
REQ-037 SHALL test streaming and wrap: write 3000 incrementing words while dout_ready toggles pseudorandomly -> all 3000 words are read in order with no gaps in the sequence.
REQ-038 SHALL test reset mid-stream: assert reset with level=500 -> next cycle level=0, dout_valid=0; the subsequent first write returns the new word, not stale data.

Source files
------------

// File: rtl/pipe_fifo_pkg.sv
// Shared definitions for the block-throttled pipe-in FIFO.
//   PIPE_FIFO_DEPTH_DEF : default capacity in words
//   PIPE_FIFO_BLOCK_DEF : default host block length in words
//   PIPE_FIFO_DW        : data word width
//   clog2()             : ceiling log2, usable in constant expressions
package pipe_fifo_pkg;

  localparam int PIPE_FIFO_DEPTH_DEF = 1024;
  localparam int PIPE_FIFO_BLOCK_DEF = 256;
  localparam int PIPE_FIFO_DW        = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_fifo_ram.sv
// Simple dual-port storage: one write port, one read port with a registered
// output (one-cycle read latency).
//   i_clk            : clock
//   i_reset          : synchronous active-high, clears only the read register
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr     : read request; data appears on o_rdata next cycle
//   o_rdata          : registered read data, held while i_re is low
module pipe_fifo_ram
  import pipe_fifo_pkg::*;
#(
  parameter int DEPTH = PIPE_FIFO_DEPTH_DEF,
  parameter int AW    = clog2(PIPE_FIFO_DEPTH_DEF),
  parameter int DW    = PIPE_FIFO_DW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pipe_in_block_fifo.sv
// First-word-fall-through FIFO between a block-throttled pipe-in endpoint and
// a valid/ready consumer. The RAM's registered read port doubles as the dout
// register, so a word written into an empty FIFO is visible two cycles later.
//   clk, reset          : clock, synchronous active-high reset
//   pipe_in_write/_data : endpoint write strobe and data
//   pipe_in_ready       : a full block of space is free (registered)
//   blockstrobe         : endpoint block-start pulse (counted)
//   dout/_valid/_ready  : downstream handshake
//   level               : words held, including the dout register
//   overflow_count      : dropped writes, saturating
//   block_count         : blockstrobe pulses, wrapping
module pipe_in_block_fifo
  import pipe_fifo_pkg::*;
#(
  parameter int DEPTH       = PIPE_FIFO_DEPTH_DEF,
  parameter int BLOCK_WORDS = PIPE_FIFO_BLOCK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_in_write,
  input  logic [15:0]           pipe_in_data,
  output logic                  pipe_in_ready,
  input  logic                  blockstrobe,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [clog2(DEPTH):0] level,
  output logic [15:0]           overflow_count,
  output logic [15:0]           block_count
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LP_FULL      = LW'(DEPTH);
  localparam logic [LW-1:0] LP_READY_MAX = LW'(DEPTH - BLOCK_WORDS);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_mem_count;   // words in RAM not yet moved to dout
  logic          r_dout_valid;
  logic          r_ready;
  logic [15:0]   r_ovf_count;
  logic [15:0]   r_blk_count;

  logic          w_full;
  logic          w_wr_acc;
  logic          w_rd_done;
  logic          w_ram_re;
  logic [LW-1:0] w_level_next;
  logic [LW-1:0] w_mem_count_next;
  logic [15:0]   w_ram_q;

  assign w_full    = (r_level == LP_FULL);
  assign w_wr_acc  = pipe_in_write & ~w_full;
  assign w_rd_done = r_dout_valid & dout_ready;
  // Refill the output register whenever it is empty or being drained.
  assign w_ram_re  = (r_mem_count != '0) & (~r_dout_valid | dout_ready);

  assign w_level_next     = r_level + LW'(w_wr_acc) - LW'(w_rd_done);
  assign w_mem_count_next = r_mem_count + LW'(w_wr_acc) - LW'(w_ram_re);

  pipe_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (16)
  ) u_ram (
    .i_clk   (clk),
    .i_reset (reset),
    .i_we    (w_wr_acc & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (pipe_in_data),
    .i_re    (w_ram_re & ~reset),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_mem_count  <= '0;
      r_dout_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_ovf_count  <= '0;
      r_blk_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_ram_re) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level     <= w_level_next;
      r_mem_count <= w_mem_count_next;
      if (w_ram_re)       r_dout_valid <= 1'b1;
      else if (w_rd_done) r_dout_valid <= 1'b0;
      r_ready <= (w_level_next <= LP_READY_MAX);
      if (pipe_in_write && w_full && (r_ovf_count != 16'hFFFF))
        r_ovf_count <= r_ovf_count + 16'd1;
      if (blockstrobe) r_blk_count <= r_blk_count + 16'd1;
    end
  end

  assign dout           = w_ram_q;
  assign dout_valid     = r_dout_valid;
  assign pipe_in_ready  = r_ready;
  assign level          = r_level;
  assign overflow_count = r_ovf_count;
  assign block_count    = r_blk_count;

endmodule

// File: tb/tb_pipe_in_block_fifo.sv
module tb_pipe_in_block_fifo;

  localparam int DEPTH = 1024;
  localparam int BW    = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_in_write = 1'b0;
  logic [15:0] pipe_in_data = '0;
  logic        pipe_in_ready;
  logic        blockstrobe = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [10:0] level;
  logic [15:0] overflow_count;
  logic [15:0] block_count;

  pipe_in_block_fifo #(.DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_in_write  (pipe_in_write),
    .pipe_in_data   (pipe_in_data),
    .pipe_in_ready  (pipe_in_ready),
    .blockstrobe    (blockstrobe),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .level          (level),
    .overflow_count (overflow_count),
    .block_count    (block_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    int          wc;
  } ent_t;

  ent_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Inputs for a cycle are applied shortly after its opening edge. A write is
  // queued as expected output when the reference occupancy says it fits.
  task automatic step(input logic wr, input logic [15:0] d, input logic rd,
                      input logic bs, input logic rst);
    ent_t e;
    @(posedge clk);
    #2;
    pipe_in_write = wr;
    pipe_in_data  = d;
    dout_ready    = rd;
    blockstrobe   = bs;
    reset         = rst;
    if (wr && !rst && q.size() < DEPTH) begin
      e.d  = d;
      e.wc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 5000) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_empty", q.size(), 0);
  endtask

  // Reference model: a word becomes visible two cycles after it is written,
  // and never earlier than the cycle after its predecessor was consumed.
  bit          armed = 0;
  bit          prev_reset = 0;
  int          last_pop = -100;
  logic [15:0] exp_ovf = 0;
  logic [15:0] exp_blk = 0;

  initial begin
    int  lvl;
    int  avail;
    bit  ev;
    forever begin
      @(negedge clk);
      lvl = q.size();
      if (lvl > 0 && q[$].wc == cyc) lvl--;
      ev = 0;
      if (lvl > 0) begin
        avail = q[0].wc + 2;
        if (last_pop + 1 > avail) avail = last_pop + 1;
        ev = (cyc >= avail);
      end
      if (armed) begin
        chk("level", 32'(level), lvl);
        chk("dout_valid", 32'(dout_valid), 32'(ev));
        chk("overflow_count", 32'(overflow_count), 32'(exp_ovf));
        chk("block_count", 32'(block_count), 32'(exp_blk));
        if (prev_reset) begin
          chk("ready_in_reset", 32'(pipe_in_ready), 0);
          chk("dout_reset", 32'(dout), 0);
        end else begin
          chk("pipe_in_ready", 32'(pipe_in_ready), 32'((DEPTH - lvl) >= BW));
        end
        if (ev) begin
          chk("dout_data", 32'(dout), 32'(q[0].d));
          if (dout_ready && !reset) begin
            void'(q.pop_front());
            last_pop = cyc;
          end
        end
      end
      if (reset) begin
        q.delete();
        exp_ovf    = 0;
        exp_blk    = 0;
        last_pop   = -100;
        prev_reset = 1;
        armed      = 1;
      end else begin
        prev_reset = 0;
        if (pipe_in_write && lvl == DEPTH && exp_ovf != 16'hFFFF) exp_ovf = exp_ovf + 16'd1;
        if (blockstrobe) exp_blk = exp_blk + 16'd1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] seq;
    int          n;

    // Reset and ready after release
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_ready", 32'(pipe_in_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_ovf", 32'(overflow_count), 0);
    chk("rst_blk", 32'(block_count), 0);

    // First-word latency
    step(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_n1_valid", 32'(dout_valid), 0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(dout_valid), 1);
    chk("lat_n2_dout", 32'(dout), 32'h0000A5A5);
    chk("lat_n2_level", 32'(level), 1);
    drain();

    // Block throttling
    for (int i = 0; i < 769; i++) step(1'b1, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("thr_level", 32'(level), 769);
    chk("thr_ready_low", 32'(pipe_in_ready), 0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("thr_level_after_read", 32'(level), 768);
    chk("thr_ready_high", 32'(pipe_in_ready), 1);
    drain();

    // Overflow
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_level_1023", 32'(level), 1023);
    chk("ovf_count_1", 32'(overflow_count), 1);
    step(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_level_1024", 32'(level), 1024);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_level_full", 32'(level), 1024);
    chk("ovf_count_2", 32'(overflow_count), 2);
    drain();

    // Streaming with wrap-around and random back-pressure
    seq = 16'h0100;
    n   = 0;
    while (seq != 16'h0100 + 16'd3000 && n < 20000) begin
      if (q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        step(1'b1, seq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b0);
        seq = seq + 16'd1;
      end else begin
        step(1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      n++;
    end
    chk("stream_all_written", 32'(seq), 32'(16'h0100 + 16'd3000));
    drain();

    // Reset mid-stream
    for (int i = 0; i < 500; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_level_500", 32'(level), 500);
    step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_new_valid", 32'(dout_valid), 1);
    chk("mid_new_dout", 32'(dout), 32'h00001234);
    drain();

    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
